// File: rtl/cfg_shadow_pkg.sv
// Shared constants and FSM state type for the configuration shadow loader.
package cfg_shadow_pkg;

  localparam int unsigned CFG_WORD_W   = 32;
  localparam int unsigned COMMIT_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StApply
  } ld_state_e;

endpackage

// File: rtl/cfg_word_bank.sv
// Shadow and active configuration word arrays with a bulk shadow-to-active copy.
// Optional registered readback port under CFG_SHADOW_READBACK_EN.
module cfg_word_bank
  import cfg_shadow_pkg::*;
#(
  parameter int unsigned            CFG_WORDS   = 16,
  parameter int unsigned            ADDR_W      = 4,
  parameter logic [CFG_WORD_W-1:0]  RESET_VALUE = '0
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [CFG_WORD_W-1:0]             wr_data,
  input  logic                              copy_en,
  output logic [CFG_WORDS*CFG_WORD_W-1:0]   active_flat
`ifdef CFG_SHADOW_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic                              rd_sel,
  output logic [CFG_WORD_W-1:0]             rd_data
`endif
);

  logic [CFG_WORD_W-1:0] shadow_q [CFG_WORDS];
  logic [CFG_WORD_W-1:0] active_q [CFG_WORDS];

  // wr_en arrives already qualified as in-range; copy reads the pre-write shadow.
  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int k = 0; k < CFG_WORDS; k++) begin
        shadow_q[k] <= RESET_VALUE;
        active_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < CFG_WORDS; k++) begin
        if (wr_en && (wr_addr == ADDR_W'(k))) begin
          shadow_q[k] <= wr_data;
        end
        if (copy_en) begin
          active_q[k] <= shadow_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < CFG_WORDS; g++) begin : g_flat
    assign active_flat[g*CFG_WORD_W +: CFG_WORD_W] = active_q[g];
  end

`ifdef CFG_SHADOW_READBACK_EN
  logic [CFG_WORD_W-1:0] rd_word;
  logic [CFG_WORD_W-1:0] rd_data_q;

  // Addresses with no matching word fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < CFG_WORDS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        rd_word = rd_sel ? shadow_q[k] : active_q[k];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_word;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/cfg_shadow_loader.sv
// Assembles a wide config vector from 32-bit writes; commits shadow to active atomically.
// Define CFG_SHADOW_READBACK_EN to add the rd_addr/rd_sel/rd_data readback port.
module cfg_shadow_loader
  import cfg_shadow_pkg::*;
#(
  parameter int unsigned            CFG_WORDS   = 16,
  parameter int unsigned            ADDR_W      = 4,
  parameter bit                     SYNC_COMMIT = 1'b1,
  parameter logic [CFG_WORD_W-1:0]  RESET_VALUE = '0
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [CFG_WORD_W-1:0]             wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic                              commit,
  input  logic                              sync_tick,
  output logic [CFG_WORDS*CFG_WORD_W-1:0]   cfg_dout,
  output logic                              cfg_updated,
  output logic                              busy,
  output logic                              addr_err,
  output logic [COMMIT_CNT_W-1:0]           commit_cnt
`ifdef CFG_SHADOW_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic                              rd_sel,
  output logic [CFG_WORD_W-1:0]             rd_data
`endif
);

  ld_state_e                 state_q, state_d;
  logic                      copy_en;
  logic                      wr_fire;
  logic                      addr_bad;
  logic                      updated_q;
  logic                      addr_err_q;
  logic [COMMIT_CNT_W-1:0]   commit_cnt_q;

  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d = (!SYNC_COMMIT || sync_tick) ? StApply : StPending;
        end
      end
      StPending: begin
        if (sync_tick) begin
          state_d = StApply;
        end
      end
      StApply: begin
        copy_en = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready depends on state only, so writes are never accepted during a copy.
  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign wr_fire  = wr_valid && wr_ready;
  assign addr_bad = (32'(wr_addr) >= CFG_WORDS);

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= StIdle;
      updated_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      updated_q  <= copy_en;
      addr_err_q <= addr_err_q || (wr_fire && addr_bad);
      if (copy_en) begin
        commit_cnt_q <= commit_cnt_q + COMMIT_CNT_W'(1);
      end
    end
  end

  assign cfg_updated = updated_q;
  assign addr_err    = addr_err_q;
  assign commit_cnt  = commit_cnt_q;

  cfg_word_bank #(
    .CFG_WORDS   (CFG_WORDS),
    .ADDR_W      (ADDR_W),
    .RESET_VALUE (RESET_VALUE)
  ) u_bank (
    .aclk        (aclk),
    .reset       (reset),
    .wr_en       (wr_fire && !addr_bad),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .copy_en     (copy_en),
    .active_flat (cfg_dout)
`ifdef CFG_SHADOW_READBACK_EN
    ,
    .rd_addr     (rd_addr),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
`endif
  );

endmodule

// File: tb/tb_cfg_shadow_loader.sv
// Bench for cfg_shadow_loader: an unsynced 12-word instance and a synced 16-word instance.
// Readback checks are compiled in with CFG_SHADOW_READBACK_EN.
module tb_cfg_shadow_loader;

  localparam logic [31:0] RA = 32'h0BAD_F00D;

  logic        aclk;
  logic        a_reset, s_reset;

  logic [3:0]  a_wr_addr, s_wr_addr;
  logic [31:0] a_wr_data, s_wr_data;
  logic        a_wr_valid, s_wr_valid, a_wr_ready, s_wr_ready;
  logic        a_commit, s_commit, a_sync, s_sync;
  logic [383:0] a_dout;
  logic [511:0] s_dout;
  logic        a_upd, s_upd, a_busy, s_busy, a_err, s_err;
  logic [15:0] a_cnt, s_cnt;
`ifdef CFG_SHADOW_READBACK_EN
  logic [3:0]  a_rd_addr, s_rd_addr;
  logic        a_rd_sel, s_rd_sel;
  logic [31:0] a_rd_data, s_rd_data;
`endif

  int checks = 0;
  int errors = 0;

  cfg_shadow_loader #(
    .CFG_WORDS   (12),
    .ADDR_W      (4),
    .SYNC_COMMIT (1'b0),
    .RESET_VALUE (RA)
  ) dut_a (
    .aclk        (aclk),
    .reset       (a_reset),
    .wr_addr     (a_wr_addr),
    .wr_data     (a_wr_data),
    .wr_valid    (a_wr_valid),
    .wr_ready    (a_wr_ready),
    .commit      (a_commit),
    .sync_tick   (a_sync),
    .cfg_dout    (a_dout),
    .cfg_updated (a_upd),
    .busy        (a_busy),
    .addr_err    (a_err),
    .commit_cnt  (a_cnt)
`ifdef CFG_SHADOW_READBACK_EN
    ,
    .rd_addr     (a_rd_addr),
    .rd_sel      (a_rd_sel),
    .rd_data     (a_rd_data)
`endif
  );

  cfg_shadow_loader #(
    .CFG_WORDS   (16),
    .ADDR_W      (4),
    .SYNC_COMMIT (1'b1),
    .RESET_VALUE (32'h0)
  ) dut_s (
    .aclk        (aclk),
    .reset       (s_reset),
    .wr_addr     (s_wr_addr),
    .wr_data     (s_wr_data),
    .wr_valid    (s_wr_valid),
    .wr_ready    (s_wr_ready),
    .commit      (s_commit),
    .sync_tick   (s_sync),
    .cfg_dout    (s_dout),
    .cfg_updated (s_upd),
    .busy        (s_busy),
    .addr_err    (s_err),
    .commit_cnt  (s_cnt)
`ifdef CFG_SHADOW_READBACK_EN
    ,
    .rd_addr     (s_rd_addr),
    .rd_sel      (s_rd_sel),
    .rd_data     (s_rd_data)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        wv;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        cm;
    int          idx;
    logic [31:0] word;
    logic        upd;
    logic        busy;
    logic        rdy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Applied for one cycle each; expected outputs are sampled after that edge.
    vecs[0]  = '{1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 3,  RA,           1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3,  RA,           1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,         1'b1, 3,  RA,           1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 4'd3,  32'h1111_1111, 1'b0, 3,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 4'd0,  32'h1234_5678, 1'b1, 0,  RA,           1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,         1'b0, 0,  32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 11, RA,           1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[8]  = '{1'b0, 4'd0,  32'h0,         1'b1, 11, RA,           1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 3,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[10] = '{1'b0, 4'd0,  32'h0,         1'b1, 3,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3};
    vecs[11] = '{1'b0, 4'd0,  32'h0,         1'b1, 3,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4};
    vecs[12] = '{1'b0, 4'd0,  32'h0,         1'b0, 3,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4};
    vecs[13] = '{1'b1, 4'd5,  32'hAAAA_0001, 1'b0, 5,  RA,           1'b0, 1'b0, 1'b1, 1'b1, 16'd4};
    vecs[14] = '{1'b1, 4'd5,  32'hBBBB_0002, 1'b1, 5,  RA,           1'b0, 1'b1, 1'b0, 1'b1, 16'd4};
    vecs[15] = '{1'b0, 4'd0,  32'h0,         1'b0, 5,  32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5};

    a_reset = 1'b1; s_reset = 1'b1;
    a_wr_addr = '0; a_wr_data = '0; a_wr_valid = 1'b0; a_commit = 1'b0; a_sync = 1'b0;
    s_wr_addr = '0; s_wr_data = '0; s_wr_valid = 1'b0; s_commit = 1'b0; s_sync = 1'b0;
`ifdef CFG_SHADOW_READBACK_EN
    a_rd_addr = '0; a_rd_sel = 1'b0; s_rd_addr = '0; s_rd_sel = 1'b0;
`endif
    step();
    step();

    // Reset state
    for (int k = 0; k < 12; k++) check($sformatf("a_rst_word%0d", k), 64'(a_dout[k*32 +: 32]), 64'(RA));
    check("a_rst_flags", {a_upd, a_busy, a_wr_ready, a_err}, 64'b0010);
    check("a_rst_cnt", 64'(a_cnt), 64'd0);
    check("s_rst_word15", 64'(s_dout[15*32 +: 32]), 64'd0);
    check("s_rst_flags", {s_upd, s_busy, s_wr_ready, s_err}, 64'b0010);
`ifdef CFG_SHADOW_READBACK_EN
    check("a_rst_rd_data", 64'(a_rd_data), 64'd0);
`endif

    a_reset = 1'b0; s_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_wr_valid = vecs[i].wv;
      a_wr_addr  = vecs[i].addr;
      a_wr_data  = vecs[i].data;
      a_commit   = vecs[i].cm;
      step();
      check($sformatf("vec%0d_word", i), 64'(a_dout[vecs[i].idx*32 +: 32]), 64'(vecs[i].word));
      check($sformatf("vec%0d_upd", i), 64'(a_upd), 64'(vecs[i].upd));
      check($sformatf("vec%0d_busy", i), 64'(a_busy), 64'(vecs[i].busy));
      check($sformatf("vec%0d_ready", i), 64'(a_wr_ready), 64'(vecs[i].rdy));
      check($sformatf("vec%0d_err", i), 64'(a_err), 64'(vecs[i].err));
      check($sformatf("vec%0d_cnt", i), 64'(a_cnt), 64'(vecs[i].cnt));
    end
    a_wr_valid = 1'b0; a_commit = 1'b0;

    // Counter wrap
    force dut_a.commit_cnt_q = 16'hFFFF;
    #1;
    release dut_a.commit_cnt_q;
    check("a_cnt_preset", 64'(a_cnt), 64'hFFFF);
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    step();
    check("a_cnt_wrap", 64'(a_cnt), 64'd0);
    check("a_wrap_upd", 64'(a_upd), 64'd1);

`ifdef CFG_SHADOW_READBACK_EN
    a_wr_valid = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'hCAFE_0003;
    step();
    a_wr_valid = 1'b0;
    a_rd_addr = 4'd3; a_rd_sel = 1'b1;
    step();
    check("a_rd_shadow3", 64'(a_rd_data), 64'hCAFE_0003);
    a_rd_sel = 1'b0;
    step();
    check("a_rd_active3", 64'(a_rd_data), 64'hDEAD_BEEF);
    a_rd_addr = 4'd14;
    step();
    check("a_rd_oor", 64'(a_rd_data), 64'd0);
`endif

    // Synced commit: shadow write alone and a lone sync_tick change nothing
    s_wr_valid = 1'b1; s_wr_addr = 4'd3; s_wr_data = 32'h5A5A_0003;
    step();
    s_wr_valid = 1'b0;
    check("s_shadow_isolated", 64'(s_dout[3*32 +: 32]), 64'd0);
    s_sync = 1'b1;
    step();
    s_sync = 1'b0;
    check("s_lone_sync", {s_upd, s_busy, s_dout[3*32 +: 32]}, 64'd0);

    s_commit = 1'b1;
    step();
    s_commit = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("s_pending_c%0d", 11 + i), {s_busy, s_wr_ready, s_upd, s_dout[3*32 +: 32]},
            {3'b100, 32'h0});
      if (i < 14) step();
    end
    s_sync = 1'b1;
    step();
    s_sync = 1'b0;
    check("s_apply_c26", {s_busy, s_wr_ready, s_upd, s_dout[3*32 +: 32]}, {3'b100, 32'h0});
    step();
    check("s_update_c27", {s_busy, s_wr_ready, s_upd, s_dout[3*32 +: 32]},
          {3'b011, 32'h5A5A_0003});
    check("s_cnt1", 64'(s_cnt), 64'd1);
    step();
    check("s_upd_once", 64'(s_upd), 64'd0);

    // Commit with coincident sync_tick
    s_wr_valid = 1'b1; s_wr_addr = 4'd4; s_wr_data = 32'h4444_0004;
    s_commit = 1'b1; s_sync = 1'b1;
    step();
    s_wr_valid = 1'b0; s_commit = 1'b0; s_sync = 1'b0;
    check("s_coinc_apply", {s_busy, s_upd, s_dout[4*32 +: 32]}, {2'b10, 32'h0});
    step();
    check("s_coinc_update", {s_busy, s_upd, s_dout[4*32 +: 32]}, {2'b01, 32'h4444_0004});
    check("s_cnt2", 64'(s_cnt), 64'd2);

    // Reset while pending aborts the commit
    s_wr_valid = 1'b1; s_wr_addr = 4'd7; s_wr_data = 32'h7777_7777;
    s_commit = 1'b1;
    step();
    s_wr_valid = 1'b0; s_commit = 1'b0;
    check("s_pend_before_rst", 64'(s_busy), 64'd1);
    s_reset = 1'b1;
    step();
    s_reset = 1'b0;
    check("s_rst_pend_flags", {s_busy, s_wr_ready, s_upd}, 64'b010);
    check("s_rst_pend_word3", 64'(s_dout[3*32 +: 32]), 64'd0);
    check("s_rst_pend_cnt", 64'(s_cnt), 64'd0);
    s_sync = 1'b1;
    step();
    s_sync = 1'b0;
    check("s_post_rst_sync1", {s_busy, s_upd}, 64'b00);
    step();
    check("s_post_rst_sync2", {s_upd, s_dout[7*32 +: 32]}, 64'd0);
    check("s_post_rst_cnt", 64'(s_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_shadow_loader.md
Name: cfg_shadow_loader

Overview:
- Upstream stage of the field slicers: assembles a wide configuration vector from 32-bit word writes issued by the PS/AXI register interface.
- Word writes land in a shadow bank. A commit copies the shadow bank into the active bank atomically, optionally aligned to a sample-sync tick.
- The active bank drives cfg_dout, which is cut into fields downstream. Slicers therefore never see a half-updated parameter set mid-scan.

Parameters:
- CFG_WORDS, 16, number of 32-bit configuration words; output width is CFG_WORDS*32.
- ADDR_W, 4, word address width; requires 2**ADDR_W >= CFG_WORDS.
- SYNC_COMMIT, 1, 1 = commit waits for sync_tick; 0 = commit applies without waiting.
- RESET_VALUE, 0, reset value of every shadow and active word (32-bit constant).

Ports:
- aclk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_addr  in  ADDR_W  word address of the write.
- wr_data  in  32  write data.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- commit  in  1  single-cycle request to apply the shadow bank.
- sync_tick  in  1  sample-rate strobe; commit alignment point.
- cfg_dout  out  CFG_WORDS*32  active bank; word k occupies bits [32k+31:32k].
- cfg_updated  out  1  one-cycle pulse in the cycle after the active bank changes.
- busy  out  1  high while a commit is pending.
- addr_err  out  1  sticky; set by an accepted write to address >= CFG_WORDS.
- commit_cnt  out  16  count of completed commits; wraps 0xFFFF -> 0.

Behaviour:
- Reset (synchronous, active-high):
  - shadow and active words = RESET_VALUE; cfg_dout = replicated RESET_VALUE.
  - cfg_updated=0, busy=0, addr_err=0, commit_cnt=0, wr_ready=1, FSM=IDLE.
  - Reset mid-PENDING aborts the commit; the active bank does not change.
- FSM states:
  - IDLE: wr_ready=1, busy=0.
  - PENDING: wr_ready=0, busy=1.
  - APPLY: one cycle; wr_ready=0, busy=1.
- Transitions:
  - IDLE + commit, when SYNC_COMMIT=0 or sync_tick is high in the same cycle -> APPLY.
  - IDLE + commit otherwise -> PENDING.
  - PENDING + sync_tick -> APPLY.
  - APPLY -> IDLE, unconditionally.
- APPLY cycle:
  - active <= shadow (all words in one edge); commit_cnt += 1.
  - cfg_updated = 1 in the following cycle only.
  - cfg_dout reflects the new bank in the same cycle cfg_updated is high.
- Latency:
  - commit to cfg_dout is 2 cycles (unsynced, or sync_tick coincident).
  - Otherwise it is 2 cycles after the first sync_tick following commit.
- Write in the same cycle as commit (IDLE): the write lands in shadow and is included in that commit.
- commit asserted while PENDING/APPLY is ignored, not queued.
- Write with address >= CFG_WORDS:
  - accepted (handshake completes), data discarded, addr_err set.
  - addr_err clears only on reset.
- Shadow writes never alter cfg_dout until a commit.
- Back-to-back writes to the same address: the last one wins.
- wr_ready is registered-state-derived only, with no combinational path from wr_valid.

Optional Feature:
- Macro: CFG_SHADOW_READBACK_EN.
- With the macro, add ports:
  - rd_addr  in  ADDR_W  word address to read.
  - rd_sel  in  1  0 = active bank, 1 = shadow bank.
  - rd_data  out  32  registered readback word.
- rd_data has 1-cycle latency; out-of-range addresses read 0; reset value is 0.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Package cfg_shadow_pkg:
  - CFG_WORD_W=32.
  - FSM state enum: IDLE, PENDING, APPLY.
  - commit counter width constant (16).
- Sub-module cfg_word_bank:
  - holds the shadow and active arrays, write port and bulk copy-enable.
  - the top keeps the FSM, handshake, error and counter logic.

Test Plan:
- Reset, then write word 3 = 0xDEADBEEF, no commit -> cfg_dout word 3 stays RESET_VALUE; commit with SYNC_COMMIT=0 -> word 3 = 0xDEADBEEF 2 cycles later, cfg_updated pulses once, commit_cnt=1.
- SYNC_COMMIT=1: commit at cycle 10, sync_tick at cycle 25 -> busy=1 and wr_ready=0 over cycles 11..26; cfg_dout updates in cycle 27.
- Write word 0 = 0x12345678 and commit in the same cycle -> the committed word 0 is 0x12345678.
- Write to address 15 with CFG_WORDS=12 -> handshake completes, addr_err=1 and stays high, cfg_dout unchanged after commit.
- Reset asserted while PENDING -> busy=0, cfg_dout = RESET_VALUE, no cfg_updated pulse; a later sync_tick causes no update.
- Force commit_cnt to 0xFFFF, then commit -> commit_cnt=0. With CFG_SHADOW_READBACK_EN: read shadow word 3 after a write, before commit -> the new value; read active word 3 -> the old value.
